// File: rtl/lsu.sv
// -----------------------------------------------------------------------------
// lsu -- load/store unit between execute and a combinational data memory.
//
// Accepts one request per handshake. Byte, half and word accesses become
// word-aligned memory cycles with byte strobes. Load data is captured, aligned
// and sign- or zero-extended. After a programmable wait the result is returned
// over a valid/ready handshake. Misaligned or illegal requests are reported
// with out_err and never touch memory.
//
// Parameters
//   LATENCY    extra wait cycles between memory access and response (0..15)
//
// Ports
//   clk, rst                        clock, asynchronous active-high reset
//   in_valid / in_ready             request handshake from execute
//   in_wen, in_funct3, in_addr,     request: store flag, RV32 size/sign,
//   in_wdata, in_rd                 byte address, store data, destination tag
//   mem_en, mem_wr, mem_addr,       data memory port (registered outputs)
//   mem_wdata, mem_wstrb, mem_rdata
//   out_valid / out_ready           response handshake to writeback
//   out_data, out_rd, out_wen,      response: aligned load data, tag,
//   out_err                         store flag, error flag
// -----------------------------------------------------------------------------
module lsu #(
  parameter int unsigned LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_wen,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [4:0]  in_rd,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_rd,
  output logic        out_wen,
  output logic        out_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Counter reload value; only meaningful when LATENCY > 0.
  localparam logic [3:0] LAT_M1 = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       req_wen;
  logic [2:0] req_funct3;
  logic [1:0] req_off;

  logic       bad;

  // Unsupported size/sign encodings for the given direction.
  function automatic logic is_illegal(input logic wen, input logic [2:0] f3);
    logic r;
    if (wen) begin
      r = (f3 > 3'b010);
    end else begin
      r = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    end
    return r;
  endfunction

  // Halves must be 2-byte aligned, words 4-byte aligned. funct3[1:0] gives
  // the size for both signed and unsigned loads.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic r;
    case (f3[1:0])
      2'b01:   r = off[0];
      2'b10:   r = (off != 2'b00);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Byte strobes for a store at the given byte offset.
  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] r;
    case (f3)
      3'b000:  r = 4'b0001 << off;
      3'b001:  r = 4'b0011 << off;
      3'b010:  r = 4'b1111;
      default: r = 4'b0000;
    endcase
    return r;
  endfunction

  // Replicate store data across every lane so the strobes pick the right one.
  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] r;
    case (f3)
      3'b000:  r = {4{wd[7:0]}};
      3'b001:  r = {2{wd[15:0]}};
      default: r = wd;
    endcase
    return r;
  endfunction

  // Select the addressed byte/half from the read word and extend it.
  function automatic logic [31:0] load_align(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] rd);
    logic [31:0] sh_b;
    logic [31:0] sh_h;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    sh_b = rd >> {off, 3'b000};
    sh_h = rd >> {off[1], 4'b0000};
    b    = sh_b[7:0];
    h    = sh_h[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b010:  r = rd;
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Request decode: anything that must be answered with an error.
  always_comb begin
    bad = 1'b0;
    if (is_illegal(in_wen, in_funct3) || is_misaligned(in_funct3, in_addr[1:0])) begin
      bad = 1'b1;
    end else begin
      bad = 1'b0;
    end
  end

  // Request/response FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      req_wen    <= 1'b0;
      req_funct3 <= 3'd0;
      req_off    <= 2'd0;
      in_ready   <= 1'b1;
      mem_en     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
      mem_wstrb  <= 4'd0;
      out_valid  <= 1'b0;
      out_data   <= 32'd0;
      out_rd     <= 5'd0;
      out_wen    <= 1'b0;
      out_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            req_wen    <= in_wen;
            req_funct3 <= in_funct3;
            req_off    <= in_addr[1:0];
            in_ready   <= 1'b0;
            mem_addr   <= {in_addr[31:2], 2'b00};
            mem_wdata  <= store_data(in_funct3, in_wdata);
            out_data   <= 32'd0;
            out_rd     <= in_rd;
            out_wen    <= in_wen;
            if (bad) begin
              // Error path skips the memory cycle entirely.
              out_err   <= 1'b1;
              out_valid <= 1'b1;
              state     <= RESP;
            end else begin
              out_err   <= 1'b0;
              mem_en    <= 1'b1;
              mem_wr    <= in_wen;
              mem_wstrb <= in_wen ? store_strb(in_funct3, in_addr[1:0]) : 4'b0000;
              state     <= ACCESS;
            end
          end
        end

        ACCESS: begin
          // Single memory cycle; load data is sampled at its end.
          mem_en    <= 1'b0;
          mem_wr    <= 1'b0;
          mem_wstrb <= 4'd0;
          out_data  <= req_wen ? 32'd0 : load_align(req_funct3, req_off, mem_rdata);
          if (LATENCY == 0) begin
            out_valid <= 1'b1;
            state     <= RESP;
          end else begin
            cnt   <= LAT_M1;
            state <= WAIT;
          end
        end

        WAIT: begin
          if (cnt == 4'd0) begin
            out_valid <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        RESP: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          mem_en    <= 1'b0;
          mem_wr    <= 1'b0;
          mem_wstrb <= 4'd0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit between the execute stage and the combinational data memory port (`en`/`wr`/`addr`/`wdata`/`wstrb`/`rdata`). It accepts one memory request per handshake from execute and converts RV32 byte/half/word accesses into word-aligned memory accesses with byte strobes. It captures and aligns/extends load data, inserts a programmable wait to emulate memory latency, and returns the result to writeback over a valid/ready handshake. Misaligned or illegal accesses are flagged without touching memory.

## Interface
- `LATENCY`, default 1: extra wait cycles between memory access and response; legal range 0..15.

- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  request valid from execute.
- `in_ready`  out  1  unit can accept a request.
- `in_wen`  in  1  1 = store, 0 = load.
- `in_funct3`  in  3  RV32 size/sign: load 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; store 000 sb, 001 sh, 010 sw.
- `in_addr`  in  32  byte address.
- `in_wdata`  in  32  store data, right-justified.
- `in_rd`  in  5  destination tag, passed through.
- `mem_en`  out  1  memory enable, to data memory `en`.
- `mem_wr`  out  1  write select, to `wr`.
- `mem_addr`  out  32  word-aligned address (`addr & ~3`).
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_wstrb`  out  4  byte strobes.
- `mem_rdata`  in  32  read word from memory (combinational, valid in the cycle `mem_en`=1, `mem_wr`=0).
- `out_valid`  out  1  response valid to writeback.
- `out_ready`  in  1  writeback accepts response.
- `out_data`  out  32  aligned, extended load data; 0 for stores and errors.
- `out_rd`  out  5  tag from request.
- `out_wen`  out  1  copy of request `in_wen`.
- `out_err`  out  1  misaligned or illegal funct3.

## Operation
- FSM: IDLE, ACCESS, WAIT, RESP. 4-bit wait counter.
- IDLE: `in_ready`=1. On `in_valid`: latch wen/funct3/addr/wdata/rd. Illegal (load funct3 011/110/111; store funct3 ≥ 011) or misaligned (half with addr[0]=1; word with addr[1:0]≠0) -> RESP, `out_err`=1, no memory cycle. Else -> ACCESS.
- ACCESS: exactly one cycle, `mem_en`=1, `mem_wr`=wen. Loads register `mem_rdata` at end of cycle. Next: WAIT (counter=LATENCY-1) if LATENCY>0, else RESP.
- WAIT: decrement counter; at 0 -> RESP.
- RESP: `out_valid`=1; outputs stable until `out_ready`; on `out_ready` -> IDLE.
- `in_ready`=0 in all states except IDLE; no overlap of requests.
- Store lanes: sb strobe `4'b0001 << addr[1:0]`, data `{4{wdata[7:0]}}`; sh strobe `4'b0011 << addr[1:0]`, data `{2{wdata[15:0]}}`; sw strobe `4'b1111`, data unchanged.
- Load align: byte = `rdata >> (8*addr[1:0])` bits [7:0]; half = `rdata >> (16*addr[1])` bits [15:0]; lb/lh sign-extend, lbu/lhu zero-extend, lw unchanged.
- Outside ACCESS: `mem_en`=0, `mem_wr`=0, `mem_wstrb`=0; `mem_addr`/`mem_wdata` hold latched values.
- A store whose ACCESS cycle has begun is committed; reset cannot retract it.

## Timing
- Reset (async): state IDLE, counter 0, `in_ready`=1, `mem_en`=0, `mem_wr`=0, `mem_wstrb`=0, `mem_addr`=0, `mem_wdata`=0, `out_valid`=0, `out_data`=0, `out_rd`=0, `out_wen`=0, `out_err`=0. Reset mid-transaction drops it; no response.
- Legal access: handshake cycle T; ACCESS at T+1; `out_valid` first high at T+2+LATENCY.
- Error access: `out_valid` first high at T+1.
- Min issue interval: 3+LATENCY cycles (legal, `out_ready` held 1); 2 cycles (error).
- `in_valid` while not IDLE is ignored; requester must hold it.

## Test plan
- Reset then lw addr 0x80000004, mem word 0x8899AABB, LATENCY=1 -> `mem_en` one cycle at T+1 with `mem_addr`=0x80000004, `out_valid` at T+3, `out_data`=0x8899AABB, `out_err`=0.
- lb/lbu addr 0x80000003, word 0x80123456 -> lb `out_data`=0xFFFFFF80; lbu 0x00000080; lh addr 0x80000002 -> 0xFFFF8012.
- sb addr 0x80000001 wdata 0x000000A5 -> `mem_wr`=1, `mem_wstrb`=0010, `mem_wdata`=0xA5A5A5A5, `mem_addr`=0x80000000; sh addr 0x80000002 wdata 0x1234 -> wstrb 1100, wdata 0x12341234.
- lw addr 0x80000002 and load funct3 011 -> `mem_en` never asserts, `out_valid` at T+1, `out_err`=1, `out_data`=0.
- Hold `out_ready`=0 for 5 cycles in RESP -> `out_valid`/`out_data`/`out_rd` stable, `in_ready`=0, new `in_valid` not accepted until cycle after `out_ready`=1.
- Assert `rst` during WAIT (LATENCY=4) -> all outputs immediately at reset values, no `out_valid`; next request completes normally.
